// File: rtl/axi_ads868x_core.sv
// ADS868x SPI ADC controller with an AXI4-Lite register bank and an AXI-Stream
// sample output. Samples are taken on a programmable period or on a pps edge.
// A register write can also issue a one-shot SPI command frame.
//
// Ports:
//   aclk, areset        - sole clock, synchronous active-high reset
//   s_axi_*             - AXI4-Lite slave for the register bank
//   m_axis_*            - AXI-Stream master, one beat per sample frame
//   pps                 - pulse-per-second trigger input
//   SCK/SS/IO0/IO1_*    - SPI tristate triplets (IO0 = MOSI, IO1 = MISO)
//   RST_PD_N, CH_SEL_*, EN_* - static ADC/front-end controls from CTRL
module axi_ads868x_core #(
  parameter int unsigned CONV_CYCLES = 128
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [31:0] s_axi_awaddr,
  input  logic [2:0]  s_axi_awprot,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [31:0] s_axi_araddr,
  input  logic [2:0]  s_axi_arprot,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  input  logic        pps,
  input  logic        SCK_I,
  output logic        SCK_O,
  output logic        SCK_T,
  input  logic        SS_I,
  output logic        SS_O,
  output logic        SS_T,
  input  logic        IO0_I,
  output logic        IO0_O,
  output logic        IO0_T,
  input  logic        IO1_I,
  output logic        IO1_O,
  output logic        IO1_T,
  output logic        RST_PD_N,
  output logic        CH_SEL_A0,
  output logic        CH_SEL_A1,
  output logic        CH_SEL_A2,
  output logic        EN_TCH_A,
  output logic        EN_PCH_A,
  output logic        EN_TCH_B,
  output logic        EN_PCH_B
);

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned DIV_W     = 8;
  localparam int unsigned EDGE_W    = 6;
  localparam logic [31:0] CTRL_MASK = 32'h0000_0F77;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CONV  = 2'd2
  } state_t;

  state_t              state_q;
  logic [DATA_W-1:0]   ctrl_q, period_q, cmd_q, rdata_q, count_q;
  logic [DIV_W-1:0]    sck_div_q, hcnt_q;
  logic [EDGE_W-1:0]   edge_q;
  logic [DATA_W-1:0]   sh_out_q, sh_in_q, conv_q, per_cnt_q, tdata_q;
  logic                overflow_q, cmd_pending_q, frame_cmd_q;
  logic                sck_o_q, ss_o_q, io0_o_q, tvalid_q;
  logic                aw_w_ready_q, bvalid_q, arready_q, rvalid_q;
  logic [DATA_W-1:0]   axi_rdata_q;
  logic                pps_d1_q, pps_d2_q;

  logic                enable_c, pps_mode_c, busy_c, pps_rise_c;
  logic                period_hit_c, trig_c, wr_fire_c, rd_fire_c;
  logic                start_cmd_c, start_smp_c;
  logic [DATA_W-1:0]   start_word_c, min_period_c, eff_period_c, rd_mux_c;

  logic unused_ok;
  assign unused_ok = ^{s_axi_awaddr[31:5], s_axi_awaddr[1:0], s_axi_awprot,
                       s_axi_araddr[31:5], s_axi_araddr[1:0], s_axi_arprot,
                       SCK_I, SS_I, IO0_I};

  // Byte-lane merge for register writes
  function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  // Trigger generation and frame-start decisions
  always_comb begin
    enable_c     = ctrl_q[0];
    pps_mode_c   = ctrl_q[2];
    busy_c       = (state_q != ST_IDLE);
    pps_rise_c   = pps_d1_q & ~pps_d2_q;
    // Shortest legal interval: 64 SCK half-periods plus the conversion time
    min_period_c = ((32'(sck_div_q) + 32'd1) << 6) + 32'(CONV_CYCLES);
    eff_period_c = (period_q < min_period_c) ? min_period_c : period_q;
    period_hit_c = (per_cnt_q >= eff_period_c - 32'd1);
    trig_c       = enable_c & (pps_mode_c ? pps_rise_c : period_hit_c);
    start_cmd_c  = (state_q == ST_IDLE) & cmd_pending_q;
    start_smp_c  = (state_q == ST_IDLE) & ~cmd_pending_q & trig_c;
    start_word_c = start_cmd_c ? cmd_q : '0;
    wr_fire_c    = aw_w_ready_q & s_axi_awvalid & s_axi_wvalid;
    rd_fire_c    = arready_q & s_axi_arvalid;
  end

  // Register read decode
  always_comb begin
    rd_mux_c = '0;
    case (s_axi_araddr[4:2])
      3'd0:    rd_mux_c = ctrl_q;
      3'd1:    rd_mux_c = {24'h0, sck_div_q};
      3'd2:    rd_mux_c = period_q;
      3'd3:    rd_mux_c = cmd_q;
      3'd4:    rd_mux_c = rdata_q;
      3'd5:    rd_mux_c = {30'h0, overflow_q, busy_c};
      3'd6:    rd_mux_c = count_q;
      default: rd_mux_c = '0;
    endcase
  end

  // pps edge detect in the aclk domain
  always_ff @(posedge aclk) begin
    if (areset) begin
      pps_d1_q <= 1'b0;
      pps_d2_q <= 1'b0;
    end else begin
      pps_d1_q <= pps;
      pps_d2_q <= pps_d1_q;
    end
  end

  // Free-running sample-period counter, held at zero when not in period mode
  always_ff @(posedge aclk) begin
    if (areset) begin
      per_cnt_q <= '0;
    end else if (!enable_c || pps_mode_c || period_hit_c) begin
      per_cnt_q <= '0;
    end else begin
      per_cnt_q <= per_cnt_q + 32'd1;
    end
  end

  // SPI frame FSM, stream output and AXI-Lite register bank
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q       <= ST_IDLE;
      ctrl_q        <= '0;
      period_q      <= '0;
      cmd_q         <= '0;
      rdata_q       <= '0;
      count_q       <= '0;
      sck_div_q     <= '0;
      hcnt_q        <= '0;
      edge_q        <= '0;
      sh_out_q      <= '0;
      sh_in_q       <= '0;
      conv_q        <= '0;
      tdata_q       <= '0;
      overflow_q    <= 1'b0;
      cmd_pending_q <= 1'b0;
      frame_cmd_q   <= 1'b0;
      sck_o_q       <= 1'b0;
      ss_o_q        <= 1'b1;
      io0_o_q       <= 1'b0;
      tvalid_q      <= 1'b0;
      aw_w_ready_q  <= 1'b0;
      bvalid_q      <= 1'b0;
      arready_q     <= 1'b0;
      rvalid_q      <= 1'b0;
      axi_rdata_q   <= '0;
    end else begin
      if (tvalid_q && m_axis_tready) begin
        tvalid_q <= 1'b0;
        count_q  <= count_q + 32'd1;
      end

      case (state_q)
        ST_IDLE: begin
          sck_o_q <= 1'b0;
          ss_o_q  <= 1'b1;
          if (start_cmd_c || start_smp_c) begin
            state_q       <= ST_SHIFT;
            ss_o_q        <= 1'b0;
            io0_o_q       <= start_word_c[31];
            sh_out_q      <= {start_word_c[30:0], 1'b0};
            hcnt_q        <= '0;
            edge_q        <= '0;
            frame_cmd_q   <= start_cmd_c;
            cmd_pending_q <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (hcnt_q >= sck_div_q) begin
            hcnt_q  <= '0;
            sck_o_q <= ~sck_o_q;
            edge_q  <= edge_q + EDGE_W'(1);
            if (!sck_o_q) begin
              sh_in_q <= {sh_in_q[30:0], IO1_I};
            end else if (edge_q == EDGE_W'(63)) begin
              // Last falling edge: release SS and publish the received word
              state_q <= ST_CONV;
              ss_o_q  <= 1'b1;
              io0_o_q <= 1'b0;
              conv_q  <= '0;
              rdata_q <= sh_in_q;
              if (!frame_cmd_q) begin
                if (tvalid_q) begin
                  overflow_q <= 1'b1;
                end else begin
                  tdata_q  <= sh_in_q;
                  tvalid_q <= 1'b1;
                end
              end
            end else begin
              io0_o_q  <= sh_out_q[31];
              sh_out_q <= {sh_out_q[30:0], 1'b0};
            end
          end else begin
            hcnt_q <= hcnt_q + DIV_W'(1);
          end
        end
        ST_CONV: begin
          // The IDLE cycle that follows completes the CONV_CYCLES quiet time
          if (conv_q + 32'd2 >= 32'(CONV_CYCLES)) begin
            state_q <= ST_IDLE;
          end else begin
            conv_q <= conv_q + 32'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      // Write channel: AW and W are accepted together
      aw_w_ready_q <= ~aw_w_ready_q & ~bvalid_q & s_axi_awvalid & s_axi_wvalid;
      if (bvalid_q && s_axi_bready) bvalid_q <= 1'b0;
      if (wr_fire_c) begin
        bvalid_q <= 1'b1;
        case (s_axi_awaddr[4:2])
          3'd0: ctrl_q   <= apply_strb(ctrl_q, s_axi_wdata, s_axi_wstrb) & CTRL_MASK;
          3'd1: if (s_axi_wstrb[0]) sck_div_q <= s_axi_wdata[7:0];
          3'd2: period_q <= apply_strb(period_q, s_axi_wdata, s_axi_wstrb);
          3'd3: begin
            cmd_q         <= apply_strb(cmd_q, s_axi_wdata, s_axi_wstrb);
            cmd_pending_q <= 1'b1;
          end
          3'd5: if (s_axi_wstrb[0] && s_axi_wdata[1]) overflow_q <= 1'b0;
          default: ;
        endcase
      end

      // Read channel: one outstanding read at a time
      arready_q <= ~arready_q & ~rvalid_q & s_axi_arvalid;
      if (rvalid_q && s_axi_rready) rvalid_q <= 1'b0;
      if (rd_fire_c) begin
        rvalid_q    <= 1'b1;
        axi_rdata_q <= rd_mux_c;
      end
    end
  end

  assign s_axi_awready = aw_w_ready_q;
  assign s_axi_wready  = aw_w_ready_q;
  assign s_axi_bresp   = 2'b00;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rdata   = axi_rdata_q;
  assign s_axi_rresp   = 2'b00;
  assign s_axi_rvalid  = rvalid_q;

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;

  assign SCK_O = sck_o_q;
  assign SCK_T = 1'b0;
  assign SS_O  = ss_o_q;
  assign SS_T  = 1'b0;
  assign IO0_O = io0_o_q;
  assign IO0_T = 1'b0;
  assign IO1_O = 1'b0;
  assign IO1_T = 1'b1;

  assign RST_PD_N  = ctrl_q[1];
  assign CH_SEL_A0 = ctrl_q[4];
  assign CH_SEL_A1 = ctrl_q[5];
  assign CH_SEL_A2 = ctrl_q[6];
  assign EN_TCH_A  = ctrl_q[8];
  assign EN_PCH_A  = ctrl_q[9];
  assign EN_TCH_B  = ctrl_q[10];
  assign EN_PCH_B  = ctrl_q[11];

endmodule

// File: tb/tb_axi_ads868x_core.sv
// Scoreboard bench for axi_ads868x_core: expected register reads and stream
// beats are queued by the stimulus and popped by independent monitors.
module tb_axi_ads868x_core;

  logic        aclk = 1'b0;
  logic        areset;
  logic [31:0] s_axi_awaddr, s_axi_wdata, s_axi_araddr, s_axi_rdata, m_axis_tdata;
  logic [2:0]  s_axi_awprot, s_axi_arprot;
  logic [3:0]  s_axi_wstrb;
  logic [1:0]  s_axi_bresp, s_axi_rresp;
  logic        s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic        s_axi_rvalid, s_axi_rready, m_axis_tvalid, m_axis_tready, pps;
  logic        SCK_I, SCK_O, SCK_T, SS_I, SS_O, SS_T;
  logic        IO0_I, IO0_O, IO0_T, IO1_I, IO1_O, IO1_T;
  logic        RST_PD_N, CH_SEL_A0, CH_SEL_A1, CH_SEL_A2;
  logic        EN_TCH_A, EN_PCH_A, EN_TCH_B, EN_PCH_B;

  always #5 aclk = ~aclk;

  axi_ads868x_core #(.CONV_CYCLES(128)) dut (
    .aclk(aclk), .areset(areset),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .pps(pps),
    .SCK_I(SCK_I), .SCK_O(SCK_O), .SCK_T(SCK_T),
    .SS_I(SS_I), .SS_O(SS_O), .SS_T(SS_T),
    .IO0_I(IO0_I), .IO0_O(IO0_O), .IO0_T(IO0_T),
    .IO1_I(IO1_I), .IO1_O(IO1_O), .IO1_T(IO1_T),
    .RST_PD_N(RST_PD_N), .CH_SEL_A0(CH_SEL_A0), .CH_SEL_A1(CH_SEL_A1), .CH_SEL_A2(CH_SEL_A2),
    .EN_TCH_A(EN_TCH_A), .EN_PCH_A(EN_PCH_A), .EN_TCH_B(EN_TCH_B), .EN_PCH_B(EN_PCH_B)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  // Scoreboard queues
  typedef struct { logic [31:0] addr; logic [31:0] exp; } rd_exp_t;
  rd_exp_t     rd_q[$];
  logic [31:0] st_q[$];
  time         beat_times[$];

  // ADC slave model: shifts adc_word out MSB first, changing on SCK falling edges
  logic [31:0] adc_word = 32'h0;
  logic [31:0] adc_sh   = 32'h0;
  bit          adc_inc  = 1'b0;
  logic [31:0] mosi_cap = 32'h0;
  logic [31:0] last_mosi = 32'h0;
  int          sck_edges = 0, last_edges = 0;
  int          frames_started = 0, frames_done = 0;
  time         t_start = 0, t_r1 = 0, t_r2 = 0;

  always @(negedge SS_O) begin
    frames_started++;
    t_start  = $time;
    mosi_cap = 32'h0;
    sck_edges = 0;
    adc_sh   = adc_word;
    IO1_I    = adc_sh[31];
  end

  always @(negedge SCK_O) begin
    if (!SS_O) begin
      adc_sh = {adc_sh[30:0], 1'b0};
      IO1_I  = adc_sh[31];
    end
  end

  always @(posedge SCK_O) begin
    if (!SS_O) begin
      mosi_cap = {mosi_cap[30:0], IO0_O};
      sck_edges++;
      if (sck_edges == 1) t_r1 = $time;
      if (sck_edges == 2) t_r2 = $time;
    end
  end

  always @(posedge SS_O) begin
    frames_done++;
    last_mosi  = mosi_cap;
    last_edges = sck_edges;
    if (adc_inc) adc_word = adc_word + 32'd1;
  end

  // Read-data monitor
  always @(negedge aclk) begin
    if (s_axi_rvalid && s_axi_rready) begin
      if (rd_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_read: got 0x%08h with no read pending", s_axi_rdata);
      end else begin
        rd_exp_t e;
        e = rd_q.pop_front();
        check($sformatf("read_0x%02h", e.addr), s_axi_rdata, e.exp);
        check($sformatf("rresp_0x%02h", e.addr), 32'(s_axi_rresp), 32'h0);
      end
    end
  end

  // Stream monitor, including stability of a stalled beat
  logic        hold_vld = 1'b0;
  logic [31:0] hold_data = 32'h0;
  always @(negedge aclk) begin
    if (m_axis_tvalid && m_axis_tready) begin
      beat_times.push_back($time);
      if (st_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_beat: got 0x%08h with nothing expected", m_axis_tdata);
      end else begin
        check("stream_tdata", m_axis_tdata, st_q.pop_front());
      end
    end
    if (m_axis_tvalid && !m_axis_tready && hold_vld)
      check("stalled_tdata_stable", m_axis_tdata, hold_data);
    hold_vld  = m_axis_tvalid && !m_axis_tready && !areset;
    hold_data = m_axis_tdata;
  end

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d);
    int n;
    @(negedge aclk);
    s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = 4'hF;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    n = 0;
    while (!(s_axi_awready && s_axi_wready) && n < 50) begin @(negedge aclk); n++; end
    if (n >= 50) begin checks++; errors++; $display("FAIL write_ready_timeout: addr 0x%02h", a); end
    @(negedge aclk);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    n = 0;
    while (!s_axi_bvalid && n < 50) begin @(negedge aclk); n++; end
    if (n >= 50) begin checks++; errors++; $display("FAIL write_bvalid_timeout: addr 0x%02h", a); end
    else check("bresp", 32'(s_axi_bresp), 32'h0);
    @(negedge aclk);
  endtask

  task automatic axi_read(input logic [31:0] a, input logic [31:0] exp);
    int n;
    rd_exp_t e;
    e.addr = a; e.exp = exp;
    rd_q.push_back(e);
    @(negedge aclk);
    s_axi_araddr = a; s_axi_arvalid = 1'b1;
    n = 0;
    while (!s_axi_arready && n < 50) begin @(negedge aclk); n++; end
    @(negedge aclk);
    s_axi_arvalid = 1'b0;
    n = 0;
    while (rd_q.size() != 0 && n < 50) begin @(negedge aclk); n++; end
    if (rd_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL read_timeout: addr 0x%02h, got no response, expected 0x%08h", a, exp);
      rd_q.delete();
    end
  endtask

  task automatic wait_beats(input int target, input int budget);
    int n;
    n = 0;
    while (beat_times.size() < target && n < budget) begin @(negedge aclk); n++; end
    check("beat_count_reached", 32'(beat_times.size()), 32'(target));
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, nb, n;
    time t_pps, lat;
    areset = 1'b1; pps = 1'b0; IO1_I = 1'b0;
    SCK_I = 1'b0; SS_I = 1'b1; IO0_I = 1'b0;
    s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b1;
    s_axi_araddr = '0; s_axi_arprot = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
    m_axis_tready = 1'b0;
    repeat (5) @(posedge aclk);
    @(negedge aclk) areset = 1'b0;
    frames_started = 0; frames_done = 0;

    // Reset state
    check("rst_SS_O", 32'(SS_O), 32'h1);
    check("rst_RST_PD_N", 32'(RST_PD_N), 32'h0);
    check("rst_SCK_O", 32'(SCK_O), 32'h0);
    check("rst_IO0_O", 32'(IO0_O), 32'h0);
    check("rst_tvalid", 32'(m_axis_tvalid), 32'h0);
    check("rst_tristates", 32'({SCK_T, SS_T, IO0_T, IO1_T, IO1_O}), 32'b00010);
    check("rst_axi_handshakes", 32'({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid}), 32'h0);
    for (int a = 0; a <= 'h18; a += 4) axi_read(32'(a), 32'h0);

    // CTRL 0xA52: rst_pd_n=1, ch_sel=3'b101, bits11:8=4'b1010 -> PCH_B=1, TCH_B=0, PCH_A=1, TCH_A=0
    axi_write(32'h00, 32'h0000_0A52);
    check("ctrl_RST_PD_N", 32'(RST_PD_N), 32'h1);
    check("ctrl_CH_SEL", 32'({CH_SEL_A2, CH_SEL_A1, CH_SEL_A0}), 32'b101);
    check("ctrl_EN_bits", 32'({EN_PCH_B, EN_TCH_B, EN_PCH_A, EN_TCH_A}), 32'b1010);
    axi_read(32'h00, 32'h0000_0A52);
    repeat (300) @(negedge aclk);
    check("ctrl_no_spi_activity", 32'(frames_started), 32'h0);

    // One-shot command frame at SCK_DIV=1
    axi_write(32'h04, 32'h1);
    adc_word = 32'h1234_5678; adc_inc = 1'b0;
    axi_write(32'h0C, 32'hD005_0000);
    axi_read(32'h14, 32'h1);
    n = 0;
    while (frames_done < 1 && n < 1000) begin @(negedge aclk); n++; end
    check("cmd_frame_done", 32'(frames_done), 32'h1);
    check("cmd_mosi", last_mosi, 32'hD005_0000);
    check("cmd_sck_edges", 32'(last_edges), 32'd32);
    check("cmd_sck_period_ns", 32'(t_r2 - t_r1), 32'd40);
    repeat (200) @(negedge aclk);
    axi_read(32'h10, 32'h1234_5678);
    axi_read(32'h14, 32'h0);
    check("cmd_no_beat", 32'(beat_times.size()), 32'h0);

    // Periodic sampling, PERIOD=1000
    adc_word = 32'h100; adc_inc = 1'b1;
    st_q.push_back(32'h100); st_q.push_back(32'h101); st_q.push_back(32'h102);
    m_axis_tready = 1'b1;
    axi_write(32'h08, 32'd1000);
    axi_write(32'h00, 32'h0000_0A53);
    wait_beats(3, 4000);
    axi_write(32'h00, 32'h0000_0A52);
    if (beat_times.size() >= 3) begin
      check("period_interval_1", 32'(beat_times[1] - beat_times[0]), 32'd10000);
      check("period_interval_2", 32'(beat_times[2] - beat_times[1]), 32'd10000);
    end
    check("period_all_popped", 32'(st_q.size()), 32'h0);
    repeat (500) @(negedge aclk);
    axi_read(32'h18, 32'd3);

    // Back-pressure across two sample periods
    m_axis_tready = 1'b0;
    axi_write(32'h00, 32'h0000_0A53);
    repeat (2400) @(negedge aclk);
    axi_write(32'h00, 32'h0000_0A52);
    repeat (500) @(negedge aclk);
    check("ovf_tvalid_held", 32'(m_axis_tvalid), 32'h1);
    check("ovf_tdata_first", m_axis_tdata, 32'h103);
    axi_read(32'h14, 32'h2);
    axi_write(32'h14, 32'h2);
    axi_read(32'h14, 32'h0);
    st_q.push_back(32'h103);
    m_axis_tready = 1'b1;
    repeat (5) @(negedge aclk);
    check("ovf_drained", 32'(st_q.size()), 32'h0);
    axi_read(32'h18, 32'd4);

    // pps mode: two pulses 5000 cycles apart
    axi_write(32'h00, 32'h0000_0A57);
    base = frames_started;
    st_q.push_back(adc_word); st_q.push_back(adc_word + 32'd1);
    for (int p = 0; p < 2; p++) begin
      @(negedge aclk);
      pps = 1'b1; t_pps = $time;
      n = 0;
      while (frames_started == base + p && n < 10) begin @(negedge aclk); n++; end
      lat = t_start - t_pps;
      checks++;
      if (frames_started != base + p + 1 || lat < 10 || lat > 30) begin
        errors++;
        $display("FAIL pps_frame_start_%0d: got %0d frames, latency %0d ns, expected 1 frame within 10..30 ns",
                 p, frames_started - base - p, lat);
      end
      repeat (10) @(negedge aclk);
      pps = 1'b0;
      repeat (4989 - n) @(negedge aclk);
    end
    repeat (2000) @(negedge aclk);
    check("pps_frame_count", 32'(frames_started - base), 32'd2);
    check("pps_beats_popped", 32'(st_q.size()), 32'h0);

    // PERIOD below the frame minimum: 64 cycles at SCK_DIV=0 plus 128
    axi_write(32'h00, 32'h0000_0A52);
    repeat (500) @(negedge aclk);
    axi_write(32'h04, 32'h0);
    axi_write(32'h08, 32'd10);
    nb = beat_times.size();
    st_q.push_back(adc_word); st_q.push_back(adc_word + 32'd1);
    axi_write(32'h00, 32'h0000_0A53);
    wait_beats(nb + 2, 1000);
    axi_write(32'h00, 32'h0000_0A52);
    if (beat_times.size() >= nb + 2)
      check("min_period_interval", 32'(beat_times[nb+1] - beat_times[nb]), 32'd1920);
    repeat (400) @(negedge aclk);

    // Reset in the middle of a command frame
    base = frames_started;
    nb = beat_times.size();
    axi_write(32'h0C, 32'hFFFF_0000);
    n = 0;
    while (frames_started == base && n < 20) begin @(negedge aclk); n++; end
    repeat (10) @(negedge aclk);
    areset = 1'b1;
    @(negedge aclk) areset = 1'b0;
    check("abort_SS_O", 32'(SS_O), 32'h1);
    check("abort_SCK_IO0", 32'({SCK_O, IO0_O}), 32'h0);
    check("abort_RST_PD_N", 32'(RST_PD_N), 32'h0);
    check("abort_tvalid", 32'(m_axis_tvalid), 32'h0);
    axi_read(32'h10, 32'h0);
    axi_read(32'h14, 32'h0);
    repeat (400) @(negedge aclk);
    check("abort_no_beat", 32'(beat_times.size()), 32'(nb));
    check("abort_no_restart", 32'(frames_started), 32'(base + 1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
